simd_vmem_ctrl: RTL and testbench
=================================

SIMD_VMEM_CTRL -- requirements
Module: simd_vmem_ctrl

Interface
REQ-001 Parameter ELEM_W, default 16, element width in bits.
REQ-002 Parameter LANES, default 16, elements per vector.
REQ-003 Parameter BEAT_LANES, default 4, elements per memory beat; SHALL divide LANES; BEATS = LANES/BEAT_LANES.
REQ-004 Parameter ADDR_W, default 32, byte-address width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 s_req  in  1  scalar access request.
REQ-009 s_we  in  1  scalar write (1) / read (0).
REQ-010 s_addr  in  ADDR_W  scalar byte address.
REQ-011 s_wdata  in  ELEM_W  scalar write data.
REQ-012 s_stall  out  1  scalar access not accepted this cycle.
REQ-013 s_rdata  out  ELEM_W  scalar read data, valid with s_rvalid.
REQ-014 s_rvalid  out  1  one-cycle pulse, scalar read data valid.
REQ-015 v_req  in  1  vector transfer request.
REQ-016 v_we  in  1  vector store (1) / load (0).
REQ-017 v_addr  in  ADDR_W  vector base byte address.
REQ-018 v_wdata  in  LANES*ELEM_W  store data, lane 0 in LSBs.
REQ-019 v_rdata  out  LANES*ELEM_W  load result register.
REQ-020 v_busy  out  1  transfer in progress.
REQ-021 v_done  out  1  one-cycle completion pulse.
REQ-022 m_en, m_we  out  1 each  memory port enable / write.
REQ-023 m_addr  out  ADDR_W  beat-aligned byte address.
REQ-024 m_wdata  out  BEAT_LANES*ELEM_W  beat write data.
REQ-025 m_lane_we  out  BEAT_LANES  per-lane write enable.
REQ-026 m_rdata  in  BEAT_LANES*ELEM_W  read data, valid the cycle after a read issue.

Function
REQ-027 FSM states SHALL be IDLE, XFER, DRAIN, DONE.
REQ-028 IDLE with v_req=1: latch v_addr (low log2(BEAT_LANES*ELEM_W/8) bits forced to 0), v_we, and v_wdata; clear beat counter; go to XFER.
REQ-029 XFER: issue beat k each cycle: m_en=1, m_we=v_we_q, m_addr=base+k*BEAT_LANES*ELEM_W/8, m_wdata=slice k, m_lane_we=all ones for stores, all zeros for loads.
REQ-030 After beat BEATS-1: store goes to DONE; load goes to DRAIN.
REQ-031 Load beat k data SHALL be written into v_rdata slice k on the cycle after its issue; DRAIN captures the last beat.
REQ-032 DONE: v_done=1 for exactly one cycle, then IDLE; v_req is sampled only in IDLE.
REQ-033 v_busy SHALL be 1 in XFER and DRAIN, 0 in IDLE and DONE.
REQ-034 v_rdata SHALL hold its value between loads; stores SHALL not modify it.
REQ-035 s_stall = (state!=IDLE) OR v_req; a simultaneous vector request wins.
REQ-036 Unstalled scalar access in IDLE: m_en=1, m_we=s_we, m_addr=s_addr beat-aligned, m_wdata=s_wdata replicated to every lane, m_lane_we one-hot at lane index s_addr[element-select bits] for writes.
REQ-037 Scalar read: s_rvalid pulses the next cycle; s_rdata = the lane of m_rdata selected by the registered lane index.
REQ-038 With no accepted request, m_en=m_we=0 and m_lane_we=0.

Reset
REQ-039 Reset SHALL force IDLE, clear beat counter, v_rdata, latched operands, s_rvalid, v_done, v_busy.
REQ-040 Reset during XFER/DRAIN SHALL abort without a v_done pulse, and no m_en SHALL be issued in the reset cycle.

Verification (defaults: BEATS=4, beat = 8 bytes)
REQ-041 Reset, idle inputs -> all outputs 0, v_rdata=0.
REQ-042 Store, v_addr=0x40, lane i = i -> m_addr 0x40,0x48,0x50,0x58 on 4 consecutive cycles, m_lane_we=4'hF, m_wdata beat0=0x0003_0002_0001_0000; v_done 5 cycles after acceptance.
REQ-043 Load, v_addr=0x43, memory returns beat k lanes = 0x10*k+lane -> addresses from 0x40, v_rdata lane 5 = 0x0011; v_done 6 cycles after acceptance.
REQ-044 s_req=1 with v_req=1 in IDLE -> s_stall=1, vector accepted; scalar retried after v_done is issued in first IDLE cycle.
REQ-045 Scalar write s_addr=0x0A, data 0xBEEF -> m_addr=0x08, m_lane_we=4'b0010; scalar read back -> s_rvalid next cycle, s_rdata=0xBEEF.
REQ-046 Reset asserted on 2nd load beat -> IDLE next cycle, no v_done, v_rdata=0, m_en=0.

Source files
------------

// File: rtl/simd_vmem_ctrl.sv
// Vector/scalar memory access controller: splits vector transfers into beats
// and shares the beat-wide memory port with single-element scalar accesses.
module simd_vmem_ctrl #(
    parameter int ELEM_W     = 16,
    parameter int LANES      = 16,
    parameter int BEAT_LANES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_req,
    input  logic                      s_we,
    input  logic [ADDR_W-1:0]         s_addr,
    input  logic [ELEM_W-1:0]         s_wdata,
    output logic                      s_stall,
    output logic [ELEM_W-1:0]         s_rdata,
    output logic                      s_rvalid,
    input  logic                      v_req,
    input  logic                      v_we,
    input  logic [ADDR_W-1:0]         v_addr,
    input  logic [LANES*ELEM_W-1:0]   v_wdata,
    output logic [LANES*ELEM_W-1:0]   v_rdata,
    output logic                      v_busy,
    output logic                      v_done,
    output logic                      m_en,
    output logic                      m_we,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [BEAT_LANES*ELEM_W-1:0] m_wdata,
    output logic [BEAT_LANES-1:0]     m_lane_we,
    input  logic [BEAT_LANES*ELEM_W-1:0] m_rdata
);

    localparam int BEATS  = LANES / BEAT_LANES;
    localparam int BEAT_W = BEAT_LANES * ELEM_W;
    localparam int OFF_W  = $clog2(BEAT_W / 8);
    localparam int EB_W   = $clog2(ELEM_W / 8);
    localparam int LSEL_W = (BEAT_LANES > 1) ? $clog2(BEAT_LANES) : 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]         base_q;
    logic                      we_q;
    logic [LANES*ELEM_W-1:0]   wdata_q;
    logic [LANES*ELEM_W-1:0]   rdata_q;
    logic                      rd_vld_q;
    logic [CNT_W-1:0]          rd_idx_q;
    logic                      s_rvalid_q;
    logic [LSEL_W-1:0]         s_lane_q;

    logic                      s_acc;
    logic                      ld_issue;
    logic [LSEL_W-1:0]         s_lane;

    wire unused_addr_bits = ^{v_addr[OFF_W-1:0], s_addr[EB_W-1:0]};

    assign s_lane = s_addr[EB_W +: LSEL_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_lane_we = '0;
        s_acc     = 1'b0;
        ld_issue  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (v_req) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end else if (s_req) begin
                    s_acc   = 1'b1;
                    m_en    = 1'b1;
                    m_we    = s_we;
                    m_addr  = {s_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    m_wdata = {BEAT_LANES{s_wdata}};
                    if (s_we) m_lane_we[s_lane] = 1'b1;
                end
            end
            XFER: begin
                m_en      = 1'b1;
                m_we      = we_q;
                m_addr    = base_q + (ADDR_W'(cnt_q) << OFF_W);
                m_wdata   = wdata_q[BEAT_W*int'(cnt_q) +: BEAT_W];
                m_lane_we = we_q ? '1 : '0;
                ld_issue  = ~we_q;
                if (cnt_q == CNT_W'(BEATS-1)) begin
                    state_d = we_q ? DONE : DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset aborts in-flight work: nothing may reach memory this cycle.
        if (reset) begin
            m_en      = 1'b0;
            m_we      = 1'b0;
            m_lane_we = '0;
            s_acc     = 1'b0;
            ld_issue  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            s_rvalid_q <= 1'b0;
            s_lane_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= ld_issue;
            rd_idx_q   <= cnt_q;
            s_rvalid_q <= s_acc & ~s_we;
            if (s_acc) s_lane_q <= s_lane;
            if (state_q == IDLE && v_req) begin
                base_q  <= {v_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                we_q    <= v_we;
                wdata_q <= v_wdata;
            end
            // Read data lags its issue by one cycle; DRAIN catches the last beat.
            if (rd_vld_q) rdata_q[BEAT_W*int'(rd_idx_q) +: BEAT_W] <= m_rdata;
        end
    end

    assign s_stall  = (state_q != IDLE) | v_req;
    assign s_rvalid = s_rvalid_q;
    assign s_rdata  = m_rdata[ELEM_W*int'(s_lane_q) +: ELEM_W];
    assign v_rdata  = rdata_q;
    assign v_busy   = ((state_q == XFER) | (state_q == DRAIN)) & ~reset;
    assign v_done   = (state_q == DONE) & ~reset;

endmodule

// File: tb/tb_simd_vmem_ctrl.sv
// Directed bench for simd_vmem_ctrl with a small element-addressed memory model.
module tb_simd_vmem_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_req, s_we;
    logic [31:0]   s_addr;
    logic [15:0]   s_wdata;
    logic          s_stall;
    logic [15:0]   s_rdata;
    logic          s_rvalid;
    logic          v_req, v_we;
    logic [31:0]   v_addr;
    logic [255:0]  v_wdata;
    logic [255:0]  v_rdata;
    logic          v_busy, v_done;
    logic          m_en, m_we;
    logic [31:0]   m_addr;
    logic [63:0]   m_wdata;
    logic [3:0]    m_lane_we;
    logic [63:0]   m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simd_vmem_ctrl dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_stall(s_stall), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
        .v_rdata(v_rdata), .v_busy(v_busy), .v_done(v_done),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_lane_we(m_lane_we), .m_rdata(m_rdata)
    );

    // Unwritten elements read back as 0x10*beat_in_group + lane.
    logic [15:0] mem [256];
    logic        wv  [256];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) wv[i] <= 1'b0;
            m_rdata <= '0;
        end else if (m_en) begin
            for (int l = 0; l < 4; l++) begin
                automatic logic [7:0] e = m_addr[8:1] + 8'(l);
                if (m_we) begin
                    if (m_lane_we[l]) begin
                        mem[e] <= m_wdata[16*l +: 16];
                        wv[e]  <= 1'b1;
                    end
                end else begin
                    m_rdata[16*l +: 16] <= wv[e] ? mem[e]
                                         : 16'(16*int'(m_addr[4:3]) + l);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        v_req = 0; v_we = 0; v_addr = 0; v_wdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    typedef struct {
        logic        s_req, s_we;
        logic [31:0] s_addr;
        logic [15:0] s_wdata;
        logic        en, we;
        logic [31:0] addr;
        logic [3:0]  lwe;
        logic [63:0] wd;
        logic        rv;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int lat;
        int pulses;
        logic [63:0]  ebeat;
        logic [255:0] evec;

        tbl[0] = '{0, 0, 32'h00, 16'h0000, 0, 0, 32'h00, 4'b0000, 64'h0, 0, 16'h0};
        tbl[1] = '{1, 1, 32'h0A, 16'hBEEF, 1, 1, 32'h08, 4'b0010, {4{16'hBEEF}}, 0, 16'h0};
        tbl[2] = '{1, 1, 32'h0E, 16'h1234, 1, 1, 32'h08, 4'b1000, {4{16'h1234}}, 0, 16'h0};
        tbl[3] = '{1, 0, 32'h0A, 16'h0000, 1, 0, 32'h08, 4'b0000, 64'h0, 0, 16'h0};
        tbl[4] = '{1, 0, 32'h0E, 16'h0000, 1, 0, 32'h08, 4'b0000, 64'h0, 1, 16'hBEEF};
        tbl[5] = '{0, 0, 32'h00, 16'h0000, 0, 0, 32'h00, 4'b0000, 64'h0, 1, 16'h1234};
        tbl[6] = '{1, 1, 32'h13, 16'h00A5, 1, 1, 32'h10, 4'b0010, {4{16'h00A5}}, 0, 16'h0};
        tbl[7] = '{1, 0, 32'h13, 16'h0000, 1, 0, 32'h10, 4'b0000, 64'h0, 0, 16'h0};
        tbl[8] = '{0, 0, 32'h00, 16'h0000, 0, 0, 32'h00, 4'b0000, 64'h0, 1, 16'h00A5};

        idle_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_m_en", 256'(m_en), 0);
        chk("rst_v_busy", 256'(v_busy), 0);
        chk("rst_v_done", 256'(v_done), 0);
        chk("rst_v_rdata", v_rdata, 0);
        reset = 0;
        next_cycle();
        @(negedge clk);
        chk("idle_outs", {s_stall, s_rvalid, s_rdata, v_busy, v_done,
                          m_en, m_we, m_addr, m_wdata, m_lane_we}, 0);
        chk("idle_v_rdata", v_rdata, 0);
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            s_req = tbl[i].s_req; s_we = tbl[i].s_we;
            s_addr = tbl[i].s_addr; s_wdata = tbl[i].s_wdata;
            @(negedge clk);
            chk($sformatf("row%0d_m_en", i), 256'(m_en), 256'(tbl[i].en));
            chk($sformatf("row%0d_m_we", i), 256'(m_we), 256'(tbl[i].we));
            chk($sformatf("row%0d_m_addr", i), 256'(m_addr), 256'(tbl[i].addr));
            chk($sformatf("row%0d_lane_we", i), 256'(m_lane_we), 256'(tbl[i].lwe));
            chk($sformatf("row%0d_m_wdata", i), 256'(m_wdata), 256'(tbl[i].wd));
            chk($sformatf("row%0d_s_stall", i), 256'(s_stall), 0);
            chk($sformatf("row%0d_s_rvalid", i), 256'(s_rvalid), 256'(tbl[i].rv));
            if (tbl[i].rv)
                chk($sformatf("row%0d_s_rdata", i), 256'(s_rdata), 256'(tbl[i].rd));
            next_cycle();
        end
        idle_inputs();

        // Store with a colliding scalar write that must wait its turn.
        do_reset();
        v_req = 1; v_we = 1; v_addr = 32'h40;
        for (int i = 0; i < 16; i++) v_wdata[16*i +: 16] = 16'(i);
        s_req = 1; s_we = 1; s_addr = 32'h0A; s_wdata = 16'hBEEF;
        @(negedge clk);
        chk("st_acc_s_stall", 256'(s_stall), 1);
        chk("st_acc_m_en", 256'(m_en), 0);
        next_cycle();
        v_req = 0; v_wdata = '0;
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) ebeat[16*l +: 16] = 16'(4*k + l);
            @(negedge clk);
            chk($sformatf("st_b%0d_m_en", k), 256'({m_en, m_we}), 256'(2'b11));
            chk($sformatf("st_b%0d_m_addr", k), 256'(m_addr), 256'(32'h40 + 8*k));
            chk($sformatf("st_b%0d_lane_we", k), 256'(m_lane_we), 256'(4'hF));
            chk($sformatf("st_b%0d_m_wdata", k), 256'(m_wdata), 256'(ebeat));
            chk($sformatf("st_b%0d_busy", k), 256'({v_busy, s_stall, v_done}),
                256'(3'b110));
            if (k == 0)
                chk("st_beat0_lit", 256'(m_wdata), 256'(64'h0003_0002_0001_0000));
            next_cycle();
            lat++;
        end
        @(negedge clk);
        while (!v_done && lat < 20) begin
            next_cycle();
            @(negedge clk);
            lat++;
        end
        chk("st_v_done", 256'(v_done), 1);
        chk("st_done_latency", 256'(lat), 5);
        chk("st_done_busy_m_en", 256'({v_busy, m_en}), 0);
        next_cycle();
        @(negedge clk);
        chk("st_retry_v_done", 256'(v_done), 0);
        chk("st_retry_s_stall", 256'(s_stall), 0);
        chk("st_retry_m_en_we", 256'({m_en, m_we}), 256'(2'b11));
        chk("st_retry_m_addr", 256'(m_addr), 256'(32'h08));
        chk("st_retry_lane_we", 256'(m_lane_we), 256'(4'b0010));
        chk("st_v_rdata_kept", v_rdata, 0);
        next_cycle();
        idle_inputs();

        // Load from a misaligned base; memory supplies the pattern data.
        do_reset();
        v_req = 1; v_we = 0; v_addr = 32'h43;
        next_cycle();
        v_req = 0; v_addr = 0;
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ld_b%0d_m_en_we", k), 256'({m_en, m_we}), 256'(2'b10));
            chk($sformatf("ld_b%0d_m_addr", k), 256'(m_addr), 256'(32'h40 + 8*k));
            chk($sformatf("ld_b%0d_lane_we", k), 256'(m_lane_we), 0);
            next_cycle();
            lat++;
        end
        @(negedge clk);
        chk("ld_drain_busy", 256'({v_busy, v_done, m_en}), 256'(3'b100));
        while (!v_done && lat < 20) begin
            next_cycle();
            @(negedge clk);
            lat++;
        end
        for (int j = 0; j < 16; j++) evec[16*j +: 16] = 16'(16*(j/4) + j%4);
        chk("ld_v_done", 256'(v_done), 1);
        chk("ld_done_latency", 256'(lat), 6);
        chk("ld_v_rdata", v_rdata, evec);
        chk("ld_lane5", 256'(v_rdata[80 +: 16]), 256'(16'h0011));
        next_cycle();
        @(negedge clk);
        chk("ld_post_done", 256'({v_done, v_busy}), 0);
        chk("ld_v_rdata_hold", v_rdata, evec);
        next_cycle();

        // Reset during the second load beat aborts the transfer.
        v_req = 1; v_we = 0; v_addr = 32'h43;
        next_cycle();
        v_req = 0;
        @(negedge clk);
        chk("ab_b0_m_en", 256'(m_en), 1);
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("ab_rst_m_en", 256'({m_en, m_we, m_lane_we}), 0);
        next_cycle();
        reset = 0;
        @(negedge clk);
        chk("ab_idle_busy_done", 256'({v_busy, v_done, s_stall}), 0);
        chk("ab_m_en", 256'(m_en), 0);
        chk("ab_v_rdata", v_rdata, 0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            @(negedge clk);
            if (v_done) pulses++;
        end
        chk("ab_no_v_done", 256'(pulses), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
